// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter owning the config register bank and fronting the read-only status bank.
// Each granted access runs IDLE -> ACCESS -> DONE, with ack pulsed for one cycle in DONE.
module reg_bank_arbiter #(
   parameter int                  NUM_REQ       = 2,
   parameter int                  NUM_CFG       = 4,
   parameter int                  NUM_STATUS    = 4,
   parameter int                  REG_WIDTH     = 8,
   parameter int                  ADDR_WIDTH    = 3,
   parameter logic [REG_WIDTH-1:0] CFG_RESET_VAL = {REG_WIDTH{1'b0}}
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            ena,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
   input  logic [NUM_REQ*REG_WIDTH-1:0]    wdata,
   output logic [NUM_REQ-1:0]              ack,
   output logic [REG_WIDTH-1:0]            rdata,
   output logic                            err,
   output logic                            busy,
   output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
   input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_WIDTH:0] CFG_LIM = (ADDR_WIDTH+1)'(NUM_CFG);
   localparam logic [ADDR_WIDTH:0] STS_LIM = (ADDR_WIDTH+1)'(NUM_CFG + NUM_STATUS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [IDXW-1:0]         last_q, last_d;
   logic [IDXW-1:0]         gnt_q, gnt_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
   logic [REG_WIDTH-1:0]    cfg_q [NUM_CFG];
   logic [REG_WIDTH-1:0]    cfg_d [NUM_CFG];
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic [REG_WIDTH-1:0]    rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;

   logic                    hi_found_s, lo_found_s;
   logic [IDXW-1:0]         hi_idx_s, lo_idx_s, pick_s;
   logic [ADDR_WIDTH:0]     addr_ext_s;
   logic [REG_WIDTH-1:0]    cfg_rd_s, sts_rd_s;

   // Round-robin pick: first request above the last grant, else the lowest one at or below it.
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = {IDXW{1'b0}};
      lo_idx_s   = {IDXW{1'b0}};
      for (int j = 0; j < NUM_REQ; j++) begin
         if (req[j] && (j > int'(last_q)) && !hi_found_s) begin
            hi_found_s = 1'b1;
            hi_idx_s   = IDXW'(j);
         end else if (req[j] && (j <= int'(last_q)) && !lo_found_s) begin
            lo_found_s = 1'b1;
            lo_idx_s   = IDXW'(j);
         end else begin
            hi_found_s = hi_found_s;
         end
      end
      pick_s = hi_found_s ? hi_idx_s : lo_idx_s;
   end

   // Read-side muxes for the latched address; status is sampled live during ACCESS.
   always_comb begin
      addr_ext_s = {1'b0, addr_q};
      cfg_rd_s   = {REG_WIDTH{1'b0}};
      sts_rd_s   = {REG_WIDTH{1'b0}};
      for (int k = 0; k < NUM_CFG; k++) begin
         cfg_rd_s = (addr_q == ADDR_WIDTH'(k)) ? cfg_q[k] : cfg_rd_s;
      end
      for (int k = 0; k < NUM_STATUS; k++) begin
         sts_rd_s = (addr_ext_s == (ADDR_WIDTH+1)'(NUM_CFG + k))
                    ? status_regs[k*REG_WIDTH +: REG_WIDTH] : sts_rd_s;
      end
   end

   // Transaction FSM next-state and datapath.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cfg_d   = cfg_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            ack_d = {NUM_REQ{1'b0}};
            if (hi_found_s || lo_found_s) begin
               gnt_d  = pick_s;
               last_d = pick_s;
               for (int j = 0; j < NUM_REQ; j++) begin
                  we_d    = (pick_s == IDXW'(j)) ? we[j] : we_d;
                  addr_d  = (pick_s == IDXW'(j)) ? addr[j*ADDR_WIDTH +: ADDR_WIDTH] : addr_d;
                  wdata_d = (pick_s == IDXW'(j)) ? wdata[j*REG_WIDTH +: REG_WIDTH] : wdata_d;
               end
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (we_q) begin
               rdata_d = {REG_WIDTH{1'b0}};
               if (addr_ext_s < CFG_LIM) begin
                  err_d = 1'b0;
                  for (int k = 0; k < NUM_CFG; k++) begin
                     cfg_d[k] = (addr_q == ADDR_WIDTH'(k)) ? wdata_q : cfg_q[k];
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else if (addr_ext_s < CFG_LIM) begin
               rdata_d = cfg_rd_s;
               err_d   = 1'b0;
            end else if (addr_ext_s < STS_LIM) begin
               rdata_d = sts_rd_s;
               err_d   = 1'b0;
            end else begin
               rdata_d = {REG_WIDTH{1'b0}};
               err_d   = 1'b1;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
               ack_d[j] = (gnt_q == IDXW'(j));
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ack_d   = {NUM_REQ{1'b0}};
            state_d = ST_IDLE;
         end
         default: begin
            ack_d   = {NUM_REQ{1'b0}};
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; ena low freezes everything, stretching the transaction.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         last_q  <= IDXW'(NUM_REQ - 1);
         gnt_q   <= {IDXW{1'b0}};
         we_q    <= 1'b0;
         addr_q  <= {ADDR_WIDTH{1'b0}};
         wdata_q <= {REG_WIDTH{1'b0}};
         for (int k = 0; k < NUM_CFG; k++) begin
            cfg_q[k] <= CFG_RESET_VAL;
         end
         ack_q   <= {NUM_REQ{1'b0}};
         rdata_q <= {REG_WIDTH{1'b0}};
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cfg_q   <= cfg_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
      assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
   end

   assign ack   = ack_q;
   assign rdata = rdata_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule
